seconds_tick_counter: RTL
=========================

// Module: seconds_tick_counter
// PURPOSE
//  Seconds stage of the countdown/stopwatch timer, directly upstream of the minutes counter.
//  Divides the system clock to a 1 Hz tick and counts seconds 00..59 up (forward) or down.
//  Drives the minutes counter: seconds[5:0], a one-cycle carry strobe (increment) and a borrow strobe (decrement).
//  Raises finish when a down-count reaches 00:00.
// PARAMETERS
//  CLK_HZ   50_000_000  system clock frequency, Hz
//  TICK_HZ  1           count rate, Hz; divide ratio DIV = CLK_HZ/TICK_HZ, must be >= 2
//  MAX_SEC  59          terminal seconds value (wrap point)
// PORTS
//  clk           in   1  system clock, single clock domain
//  reset         in   1  asynchronous, active-high reset
//  enable        in   1  1 = prescaler and counter advance; 0 = freeze, state held
//  forward       in   1  1 = count up (stopwatch), 0 = count down (timer)
//  start         in   1  level, sampled each clk: IDLE/PAUSED -> RUN
//  pause         in   1  level, sampled each clk: RUN -> PAUSED
//  clear         in   1  synchronous clear to IDLE, seconds = 0
//  load          in   1  IDLE only: seconds <= load_value
//  load_value    in   6  preset; values > MAX_SEC are clamped to MAX_SEC
//  minutes_zero  in   1  minutes counter currently at 0 (from downstream)
//  seconds       out  6  current seconds value
//  increment     out  1  one-cycle strobe: up-count wrapped MAX_SEC -> 0
//  decrement     out  1  one-cycle strobe: down-count wrapped 0 -> MAX_SEC
//  tick_1hz      out  1  one-cycle prescaler strobe (asserted in RUN only)
//  finish        out  1  high while in DONE
//  state         out  2  IDLE=0, RUN=1, PAUSED=2, DONE=3
// BEHAVIOUR
//  Reset: state=IDLE, seconds=0, prescaler=0; increment, decrement, tick_1hz, finish = 0.
//  Prescaler: counts 0..DIV-1 in RUN with enable=1; tick_1hz=1 on the cycle count==DIV-1, then count wraps to 0.
//   It holds its count in PAUSED or when enable=0, and clears to 0 on entry to IDLE or DONE.
//  Priority per cycle: reset > clear > load > pause > start > tick. enable=0 blocks all except reset and clear.
//  FSM transitions:
//   IDLE  -start->          RUN
//   RUN   -pause->          PAUSED
//   PAUSED-start->          RUN
//   RUN   -down end->       DONE
//   DONE  -clear->          IDLE; start is ignored in DONE
//   any   -clear->          IDLE
//  Tick in RUN, forward=1: seconds==MAX_SEC -> seconds=0 and increment=1 in the same cycle; otherwise seconds+1.
//  Tick in RUN, forward=0:
//   seconds==0 and minutes_zero=1 -> state=DONE, seconds stays 0, no strobe.
//   seconds==0 and minutes_zero=0 -> seconds=MAX_SEC and decrement=1.
//   otherwise seconds-1.
//  Latency: seconds and the strobes are registered; they update on the clk edge that ends the tick_1hz cycle.
//  Strobes are exactly one clk wide and never asserted together.
//  forward may change at any time; it takes effect on the next tick. No partial-second correction is made.
//  load outside IDLE is ignored. clear mid-second discards the partial prescaler count.
//  Width: all arithmetic is 6-bit unsigned; no value outside 0..MAX_SEC is ever reachable.
// STRUCTURE
//  Shared timer package: state encodings (ST_IDLE, ST_RUN, ST_PAUSED, ST_DONE) and SEC_MAX=59.
//   The minutes stage reuses SEC_MAX.
//  One sub-module, tick_prescaler (params DIV; ports clk, reset, run, clr, tick), instanced once.
//  FSM and seconds datapath live in this module.
// TESTING
//  (Bench uses DIV=4.)
//  T1 reset mid-RUN with seconds=17 -> all outputs 0, state=IDLE on the same edge (async).
//  T2 forward=1, load 58, start -> ticks give 59, then 0 with increment=1 for one clk; decrement never asserts.
//  T3 forward=0, seconds=0, minutes_zero=0 -> tick gives seconds=59 and a decrement pulse.
//     Repeat with minutes_zero=1 -> state=DONE, finish=1, seconds stays 0.
//  T4 RUN, pause after 2 of 4 prescaler clks, hold 10 clks, start -> next tick arrives 2 clks after resume.
//  T5 simultaneous clear+start, and load_value=63 in IDLE -> clear wins, state=IDLE; load clamps seconds to 59.
//  T6 enable=0 for 20 clks during RUN -> no tick, no seconds change; counting resumes when enable=1.

Source files
------------

// File: rtl/seconds_tick_counter_pkg.sv
// Shared timer definitions: FSM state encodings and the seconds wrap point.
// The minutes stage imports the same package and reuses SEC_MAX.
package seconds_tick_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [5:0] SEC_MAX = 6'd59;

    function automatic logic [5:0] clamp_sec(input logic [5:0] value, input logic [5:0] max_value);
        return (value > max_value) ? max_value : value;
    endfunction

endpackage

// File: rtl/seconds_tick_counter_if.sv
// Control/status bundle between the timer front panel logic (master) and the seconds stage (slave).
interface seconds_tick_counter_if;
    logic       enable;
    logic       forward;
    logic       start;
    logic       pause;
    logic       clear;
    logic       load;
    logic [5:0] load_value;
    logic       minutes_zero;
    logic [5:0] seconds;
    logic       increment;
    logic       decrement;
    logic       tick_1hz;
    logic       finish;
    logic [1:0] state;

    modport master (
        output enable, forward, start, pause, clear, load, load_value, minutes_zero,
        input  seconds, increment, decrement, tick_1hz, finish, state
    );

    modport slave (
        input  enable, forward, start, pause, clear, load, load_value, minutes_zero,
        output seconds, increment, decrement, tick_1hz, finish, state
    );
endinterface

// File: rtl/seconds_tick_counter_tick_prescaler.sv
// Divide-by-DIV prescaler: counts 0..DIV-1 while run_i is high, strobing tick_o on the last count.
// Holds when run_i is low; clr_i discards any partial count.
module tick_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    input  logic clr_i,
    output logic tick_o
);
    localparam int            CW   = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = run_i && !clr_i && (cnt_q == LAST);
endmodule

// File: rtl/seconds_tick_counter.sv
// Seconds stage of the countdown/stopwatch timer: 1 Hz prescaler, run/pause FSM and the
// 00..MAX_SEC up/down counter that feeds carry/borrow strobes to the minutes stage.
module seconds_tick_counter
    import seconds_tick_counter_pkg::*;
#(
    parameter int         CLK_HZ  = 50_000_000,
    parameter int         TICK_HZ = 1,
    parameter logic [5:0] MAX_SEC = SEC_MAX
) (
    input  logic                  clk,
    input  logic                  rst,
    seconds_tick_counter_if.slave bus
);
    localparam int DIV = CLK_HZ / TICK_HZ;

    state_e     state_q, state_d;
    logic [5:0] sec_q, sec_d;
    logic       inc_q, inc_d;
    logic       dec_q, dec_d;
    logic       run;
    logic       tick;

    // Prescaler only advances on cycles where RUN actually continues; a pause or clear
    // in the same cycle takes priority over the tick and freezes the partial second.
    assign run = (state_q == ST_RUN) && bus.enable && !bus.clear && !bus.pause;

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .run_i  (run),
        .clr_i  (bus.clear),
        .tick_o (tick)
    );

    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        inc_d   = 1'b0;
        dec_d   = 1'b0;
        if (bus.clear) begin
            state_d = ST_IDLE;
            sec_d   = '0;
        end else if (bus.enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.load) begin
                        sec_d = clamp_sec(bus.load_value, MAX_SEC);
                    end else if (bus.start) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.pause) begin
                        state_d = ST_PAUSED;
                    end else if (tick) begin
                        if (bus.forward) begin
                            if (sec_q >= MAX_SEC) begin
                                sec_d = '0;
                                inc_d = 1'b1;
                            end else begin
                                sec_d = sec_q + 6'd1;
                            end
                        end else if (sec_q == 6'd0) begin
                            if (bus.minutes_zero) begin
                                state_d = ST_DONE;
                            end else begin
                                sec_d = MAX_SEC;
                                dec_d = 1'b1;
                            end
                        end else begin
                            sec_d = sec_q - 6'd1;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (bus.start) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sec_q   <= '0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
        end
    end

    assign bus.seconds   = sec_q;
    assign bus.increment = inc_q;
    assign bus.decrement = dec_q;
    assign bus.tick_1hz  = tick;
    assign bus.finish    = (state_q == ST_DONE);
    assign bus.state     = state_q;
endmodule
